// File: rtl/rf_writeback_unit.sv
// Writeback unit for the 16x32 register file: merges ALU and load results into
// a small FIFO, retires one write per cycle and tracks pending writes per register.
module rf_writeback_unit #(
    parameter int bits_palavra  = 32,
    parameter int end_registros = 4,
    parameter int fifo_depth    = 4
) (
    input  logic                             clock,
    input  logic                             reset,

    input  logic                             alu_valid,
    input  logic [end_registros-1:0]         alu_dest,
    input  logic [bits_palavra-1:0]          alu_data,
    output logic                             alu_ready,

    input  logic                             mem_valid,
    input  logic [end_registros-1:0]         mem_dest,
    input  logic [bits_palavra-1:0]          mem_data,
    output logic                             mem_ready,

    input  logic                             read_req,

    input  logic                             issue_valid,
    input  logic [end_registros-1:0]         issue_dest,
    output logic                             issue_ready,

    input  logic [end_registros-1:0]         chk_a,
    input  logic [end_registros-1:0]         chk_b,
    output logic                             busy_a,
    output logic                             busy_b,

    output logic                             enable,
    output logic [end_registros-1:0]         IN_C,
    output logic [bits_palavra-1:0]          E,
    output logic [$clog2(fifo_depth+1)-1:0]  fifo_count
);

    localparam int num_regs = 1 << end_registros;
    localparam int ptr_w    = $clog2(fifo_depth);
    localparam int cnt_w    = $clog2(fifo_depth + 1);
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

    logic [end_registros-1:0] dest_q [fifo_depth];
    logic [bits_palavra-1:0]  data_q [fifo_depth];

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w-1:0] alu_slot;
    logic [cnt_w-1:0] count;
    logic [cnt_w-1:0] free;

    logic push_mem;
    logic push_alu;
    logic pop;

    logic [1:0]          sb [num_regs];
    logic [num_regs-1:0] sb_inc;
    logic [num_regs-1:0] sb_dec;

    // Free space looks at the current count only; a same-cycle pop gives no credit.
    assign free      = depth_c - count;
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= cnt_w'(2)) || ((free != '0) && !mem_valid);

    assign push_mem = mem_valid && mem_ready;
    assign push_alu = alu_valid && alu_ready;
    assign pop      = (count != '0) && !read_req;

    // The load is the older operation, so it takes the first free slot.
    assign alu_slot = push_mem ? wr_ptr + ptr_w'(1) : wr_ptr;

    assign fifo_count = count;

    always_ff @(posedge clock) begin
        if (push_mem) begin
            dest_q[wr_ptr] <= mem_dest;
            data_q[wr_ptr] <= mem_data;
        end
        if (push_alu) begin
            dest_q[alu_slot] <= alu_dest;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_w'(push_mem) + ptr_w'(push_alu);
            rd_ptr <= rd_ptr + ptr_w'(pop);
            count  <= count + cnt_w'(push_mem) + cnt_w'(push_alu) - cnt_w'(pop);
        end
    end

    // Write port is registered; address and data hold when nothing retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            IN_C   <= '0;
            E      <= '0;
        end else begin
            enable <= pop;
            if (pop) begin
                IN_C <= dest_q[rd_ptr];
                E    <= data_q[rd_ptr];
            end
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (issue_valid && issue_ready) begin
            sb_inc[issue_dest] = 1'b1;
        end
        if (enable) begin
            sb_dec[IN_C] = 1'b1;
        end
    end

    // A decrement of an idle register is a producer error and saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_regs; i++) begin
                sb[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < num_regs; i++) begin
                if (sb_inc[i] && !sb_dec[i]) begin
                    sb[i] <= sb[i] + 2'd1;
                end else if (sb_dec[i] && !sb_inc[i] && (sb[i] != 2'd0)) begin
                    sb[i] <= sb[i] - 2'd1;
                end
            end
        end
    end

    assign issue_ready = (sb[issue_dest] != 2'd3);
    assign busy_a      = (sb[chk_a] != 2'd0);
    assign busy_b      = (sb[chk_b] != 2'd0);

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed self-checking bench for rf_writeback_unit: handshake, FIFO ordering,
// read_req stall, backpressure, scoreboard and asynchronous reset.
module tb_rf_writeback_unit;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        read_req;
    logic        issue_valid;
    logic [3:0]  issue_dest;
    logic        issue_ready;
    logic [3:0]  chk_a;
    logic [3:0]  chk_b;
    logic        busy_a;
    logic        busy_b;
    logic        enable;
    logic [3:0]  IN_C;
    logic [31:0] E;
    logic [2:0]  fifo_count;

    int checks;
    int errors;

    rf_writeback_unit dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_dest    (alu_dest),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_dest    (mem_dest),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .read_req    (read_req),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .enable      (enable),
        .IN_C        (IN_C),
        .E           (E),
        .fifo_count  (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advances the given number of rising edges and settles 1 time unit after the last one.
    task automatic applyStimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    logic [3:0]  exp_dest [5];
    logic [31:0] exp_data [5];

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_dest    = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_dest    = '0;
        mem_data    = '0;
        read_req    = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = '0;
        chk_a       = '0;
        chk_b       = '0;

        applyStimulus(2);
        checkOutput("rst_enable", 32'(enable), 32'd0);
        checkOutput("rst_in_c", 32'(IN_C), 32'd0);
        checkOutput("rst_e", E, 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("rst_busy_a", 32'(busy_a), 32'd0);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;

        // Single ALU write: accept, one cycle of enable, then idle.
        alu_valid = 1'b1;
        alu_dest  = 4'd5;
        alu_data  = 32'h0000_00AA;
        applyStimulus(1);
        alu_valid = 1'b0;
        checkOutput("t1_count", 32'(fifo_count), 32'd1);
        checkOutput("t1_no_bypass", 32'(enable), 32'd0);
        applyStimulus(1);
        checkOutput("t1_enable", 32'(enable), 32'd1);
        checkOutput("t1_in_c", 32'(IN_C), 32'd5);
        checkOutput("t1_e", E, 32'h0000_00AA);
        checkOutput("t1_count0", 32'(fifo_count), 32'd0);
        chk_a = 4'd5;
        applyStimulus(1);
        checkOutput("t1_enable_low", 32'(enable), 32'd0);
        checkOutput("t1_in_c_hold", 32'(IN_C), 32'd5);
        checkOutput("t1_e_hold", E, 32'h0000_00AA);
        checkOutput("t1_sb_no_wrap", 32'(busy_a), 32'd0);

        // Both sources together: mem retires before ALU.
        mem_valid = 1'b1;
        mem_dest  = 4'd3;
        mem_data  = 32'h1111_1111;
        alu_valid = 1'b1;
        alu_dest  = 4'd4;
        alu_data  = 32'h2222_2222;
        #1;
        checkOutput("t2_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("t2_mem_ready", 32'(mem_ready), 32'd1);
        applyStimulus(1);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        checkOutput("t2_count", 32'(fifo_count), 32'd2);
        applyStimulus(1);
        checkOutput("t2_w1_enable", 32'(enable), 32'd1);
        checkOutput("t2_w1_in_c", 32'(IN_C), 32'd3);
        checkOutput("t2_w1_e", E, 32'h1111_1111);
        applyStimulus(1);
        checkOutput("t2_w2_enable", 32'(enable), 32'd1);
        checkOutput("t2_w2_in_c", 32'(IN_C), 32'd4);
        checkOutput("t2_w2_e", E, 32'h2222_2222);
        applyStimulus(1);
        checkOutput("t2_idle", 32'(enable), 32'd0);

        // read_req stall fills the FIFO, release drains back-to-back.
        read_req  = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_dest = 4'(8 + i);
            alu_data = 32'h0000_00A0 + 32'(i);
            applyStimulus(1);
            checkOutput("t3_stall_enable", 32'(enable), 32'd0);
        end
        alu_valid = 1'b0;
        checkOutput("t3_full_count", 32'(fifo_count), 32'd4);
        checkOutput("t3_full_alu_ready", 32'(alu_ready), 32'd0);
        checkOutput("t3_full_mem_ready", 32'(mem_ready), 32'd0);
        read_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("t3_drain_enable", 32'(enable), 32'd1);
            checkOutput("t3_drain_in_c", 32'(IN_C), 32'(8 + i));
            checkOutput("t3_drain_e", E, 32'h0000_00A0 + 32'(i));
        end
        applyStimulus(1);
        checkOutput("t3_drain_done", 32'(enable), 32'd0);
        checkOutput("t3_drain_count", 32'(fifo_count), 32'd0);

        // Count 3 with both valid: only mem fits, ALU waits holding its data.
        exp_dest[0] = 4'd1;  exp_data[0] = 32'h0000_0010;
        exp_dest[1] = 4'd2;  exp_data[1] = 32'h0000_0011;
        exp_dest[2] = 4'd3;  exp_data[2] = 32'h0000_0012;
        exp_dest[3] = 4'd6;  exp_data[3] = 32'h6666_6666;
        exp_dest[4] = 4'd12; exp_data[4] = 32'hCCCC_CCCC;
        read_req  = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_dest = exp_dest[i];
            alu_data = exp_data[i];
            applyStimulus(1);
        end
        mem_valid = 1'b1;
        mem_dest  = exp_dest[3];
        mem_data  = exp_data[3];
        alu_dest  = exp_dest[4];
        alu_data  = exp_data[4];
        #1;
        checkOutput("t4_count3", 32'(fifo_count), 32'd3);
        checkOutput("t4_mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("t4_alu_ready", 32'(alu_ready), 32'd0);
        applyStimulus(1);
        mem_valid = 1'b0;
        checkOutput("t4_count4", 32'(fifo_count), 32'd4);
        checkOutput("t4_alu_blocked", 32'(alu_ready), 32'd0);
        read_req = 1'b0;
        applyStimulus(1);
        checkOutput("t4_w0_in_c", 32'(IN_C), 32'(exp_dest[0]));
        checkOutput("t4_no_pop_credit", 32'(fifo_count), 32'd3);
        checkOutput("t4_alu_ready_now", 32'(alu_ready), 32'd1);
        applyStimulus(1);
        alu_valid = 1'b0;
        checkOutput("t4_w1_in_c", 32'(IN_C), 32'(exp_dest[1]));
        checkOutput("t4_count_push_pop", 32'(fifo_count), 32'd3);
        for (int i = 2; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("t4_order_enable", 32'(enable), 32'd1);
            checkOutput("t4_order_in_c", 32'(IN_C), 32'(exp_dest[i]));
            checkOutput("t4_order_e", E, exp_data[i]);
        end
        applyStimulus(1);
        checkOutput("t4_idle", 32'(enable), 32'd0);

        // Scoreboard on register 7: saturate at 3, retire, same-edge issue and retire.
        chk_a       = 4'd7;
        chk_b       = 4'd7;
        issue_dest  = 4'd7;
        issue_valid = 1'b1;
        applyStimulus(1);
        checkOutput("t5_busy_after_one", 32'(busy_a), 32'd1);
        applyStimulus(2);
        checkOutput("t5_full_issue_ready", 32'(issue_ready), 32'd0);
        checkOutput("t5_full_busy_b", 32'(busy_b), 32'd1);
        applyStimulus(1);
        issue_valid = 1'b0;
        checkOutput("t5_no_wrap_up", 32'(busy_a), 32'd1);
        checkOutput("t5_still_full", 32'(issue_ready), 32'd0);
        alu_valid = 1'b1;
        alu_dest  = 4'd7;
        alu_data  = 32'h0000_0071;
        applyStimulus(1);
        alu_data  = 32'h0000_0072;
        applyStimulus(1);
        alu_valid = 1'b0;
        checkOutput("t5_r1_in_c", 32'(IN_C), 32'd7);
        checkOutput("t5_r1_e", E, 32'h0000_0071);
        applyStimulus(2);
        checkOutput("t5_two_left_one", 32'(issue_ready), 32'd1);
        checkOutput("t5_one_busy", 32'(busy_a), 32'd1);
        alu_valid = 1'b1;
        alu_data  = 32'h0000_0073;
        applyStimulus(1);
        alu_valid = 1'b0;
        applyStimulus(1);
        checkOutput("t5_same_edge_enable", 32'(enable), 32'd1);
        issue_valid = 1'b1;
        applyStimulus(2);
        checkOutput("t5_same_edge_not_inc", 32'(issue_ready), 32'd1);
        applyStimulus(1);
        issue_valid = 1'b0;
        checkOutput("t5_same_edge_not_dec", 32'(issue_ready), 32'd0);
        alu_valid = 1'b1;
        alu_data  = 32'h0000_0074;
        applyStimulus(3);
        alu_valid = 1'b0;
        applyStimulus(1);
        checkOutput("t5_last_busy", 32'(busy_a), 32'd1);
        applyStimulus(1);
        checkOutput("t5_clear_a", 32'(busy_a), 32'd0);
        checkOutput("t5_clear_b", 32'(busy_b), 32'd0);
        applyStimulus(1);

        // Asynchronous reset while a write is on the port with two entries behind it.
        read_req  = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_dest = 4'(13 + i);
            alu_data = 32'hD000_0000 + 32'(i);
            applyStimulus(1);
        end
        alu_valid = 1'b0;
        read_req  = 1'b0;
        applyStimulus(1);
        checkOutput("t6_pre_enable", 32'(enable), 32'd1);
        checkOutput("t6_pre_in_c", 32'(IN_C), 32'd13);
        checkOutput("t6_pre_count", 32'(fifo_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_enable", 32'(enable), 32'd0);
        checkOutput("t6_async_count", 32'(fifo_count), 32'd0);
        checkOutput("t6_async_in_c", 32'(IN_C), 32'd0);
        checkOutput("t6_async_e", E, 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t6_post_enable", 32'(enable), 32'd0);
            checkOutput("t6_post_count", 32'(fifo_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
